// File: rtl/boot_store_pkg.sv
// Shared types and boot image constant for the boot_store memory.
package boot_store_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam int BOOT_LEN = 7;

    localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
        16'hF200, 16'h4000, 16'hF800, 16'h1007,
        16'hF400, 16'h3007, 16'h4000
    };

    // Words past the end of the image read as zero.
    function automatic logic [15:0] boot_word(input int idx);
        boot_word = '0;
        for (int i = 0; i < BOOT_LEN; i++) begin
            if (idx == i) boot_word = BOOT_IMAGE[i];
        end
    endfunction

endpackage

// File: rtl/boot_store_parity.sv
// Even-parity generator for write data and checker for read data.
module boot_store_parity #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] wdata,
    output logic          wpar,
    input  logic [DW-1:0] rdata,
    input  logic          rpar,
    output logic          err
);

    assign wpar = ^wdata;
    assign err  = (^rdata) ^ rpar;

endmodule

// File: rtl/boot_store.sv
// Boot ROM image plus writable scratch words with a sequenced clear.
// Optional per-word parity when BOOT_STORE_PARITY_EN is defined.
module boot_store
    import boot_store_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AW        = 4,
    parameter int ROM_WORDS = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          clr,
    output logic [DW-1:0] dout,
    output logic          rvalid,
    output logic          busy,
    output logic          wr_err,
    output logic          perr
);

    localparam int            DEPTH   = 2 ** AW;
    localparam logic [AW-1:0] FIRST_W = AW'(ROM_WORDS);
    localparam logic [AW-1:0] LAST_W  = AW'(DEPTH - 1);
    localparam logic [AW:0]   ROM_LIM = (AW+1)'(ROM_WORDS);
    localparam bit            NO_RW   = (ROM_WORDS >= DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] mem [DEPTH];

    logic          rom_hit;
    logic          rd_go;
    logic          err_d;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] rdata;

    assign rom_hit = {1'b0, addr} < ROM_LIM;
    assign rdata   = rom_hit ? DW'(boot_word(int'(addr))) : mem[addr];
    assign busy    = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rd_go   = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = addr;
        mem_wd  = din;
        unique case (state_q)
            IDLE: begin
                // A clear request wins over any access in the same cycle.
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = FIRST_W;
                    err_d   = cs && we;
                end else if (cs && we) begin
                    if (rom_hit) err_d  = 1'b1;
                    else         mem_we = 1'b1;
                end else if (cs) begin
                    rd_go = 1'b1;
                end
            end
            CLEAR: begin
                err_d = cs && we;
                if (NO_RW) begin
                    state_d = IDLE;
                end else begin
                    mem_we = 1'b1;
                    mem_wa = ptr_q;
                    mem_wd = '0;
                    if (ptr_q == LAST_W) state_d = IDLE;
                    else                 ptr_d   = ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            rvalid <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            rvalid <= rd_go;
            wr_err <= err_d;
            if (rd_go) dout <= rdata;
        end
    end

`ifdef BOOT_STORE_PARITY_EN
    logic [DEPTH-1:0] par;
    logic             wpar;
    logic             par_err;
    logic             perr_q;

    boot_store_parity #(.DW(DW)) u_parity (
        .wdata (mem_wd),
        .wpar  (wpar),
        .rdata (mem[addr]),
        .rpar  (par[addr]),
        .err   (par_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par    <= '0;
            perr_q <= 1'b0;
        end else begin
            if (mem_we) par[mem_wa] <= wpar;
            if (rd_go)  perr_q      <= !rom_hit && par_err;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule
